conv_seq_ctrl: RTL and testbench

- Sequencer for the 128x32 convolution datapath: F memory, X shift-window memory, pipelined multiply/adder tree.
- Runs the AXI-style loads of F and X, advances the datapath pipeline, and tracks which pipeline slots hold real windows.
- Drives m_valid_y under m_ready_y backpressure, counts the X_SIZE-F_SIZE+1 results, then pulses conv_done and re-arms for the next frame.

---
 rtl/conv_seq_ctrl.sv | 138 +++++++++++++
 tb/tb_conv_seq_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_seq_ctrl.sv
// rtl/conv_seq_ctrl.sv - control sequencer for the F/X loaded convolution datapath
// Loads F, streams X through the window, tracks real windows down the pipe, counts outputs.
module conv_seq_ctrl #(
  parameter int X_SIZE       = 128,
  parameter int F_SIZE       = 32,
  parameter int PLINE_STAGES = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      s_valid_f,
  output logic                      s_ready_f,
  output logic                      fmem_wr_en,
  output logic [$clog2(F_SIZE)-1:0] fmem_addr,
  input  logic                      s_valid_x,
  output logic                      s_ready_x,
  output logic                      xmem_wr_en,
  output logic                      en_pline_stages,
  output logic                      pline_clr,
  output logic                      conv_start,
  output logic                      m_valid_y,
  input  logic                      m_ready_y,
  output logic                      conv_done
);

  localparam int N_OUT = X_SIZE - F_SIZE + 1;
  localparam int XC_W  = $clog2(X_SIZE + 1);
  localparam int FC_W  = $clog2(F_SIZE + 1);
  localparam int FA_W  = $clog2(F_SIZE);

  localparam logic [FC_W-1:0] F_LAST     = FC_W'(F_SIZE - 1);
  localparam logic [XC_W-1:0] X_LAST     = XC_W'(X_SIZE - 1);
  localparam logic [XC_W-1:0] X_FULL     = XC_W'(X_SIZE);
  localparam logic [XC_W-1:0] X_WIN_FIRST = XC_W'(F_SIZE - 1);
  localparam logic [XC_W-1:0] N_LAST     = XC_W'(N_OUT - 1);

  typedef enum logic [1:0] {
    ST_LOAD_F = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [FC_W-1:0]         f_cnt_q, f_cnt_d;
  logic [XC_W-1:0]         x_cnt_q, x_cnt_d;
  logic [XC_W-1:0]         out_cnt_q, out_cnt_d;
  logic                    win_pend_q, win_pend_d;
  logic [PLINE_STAGES-1:0] vbit_q, vbit_d;
  logic                    adv;

  // Any stage may move only when the output register is free to change.
  assign m_valid_y = vbit_q[PLINE_STAGES-1];
  assign adv       = ~m_valid_y | m_ready_y;
  assign fmem_addr = f_cnt_q[FA_W-1:0];

  always_comb begin
    state_d         = state_q;
    f_cnt_d         = f_cnt_q;
    x_cnt_d         = x_cnt_q;
    out_cnt_d       = out_cnt_q;
    win_pend_d      = win_pend_q;
    vbit_d          = vbit_q;
    s_ready_f       = 1'b0;
    fmem_wr_en      = 1'b0;
    s_ready_x       = 1'b0;
    xmem_wr_en      = 1'b0;
    en_pline_stages = 1'b0;
    pline_clr       = 1'b0;
    conv_start      = 1'b0;
    conv_done       = 1'b0;

    case (state_q)
      ST_LOAD_F: begin
        s_ready_f  = 1'b1;
        pline_clr  = 1'b1;
        fmem_wr_en = s_valid_f;
        if (fmem_wr_en) begin
          f_cnt_d = f_cnt_q + FC_W'(1);
          if (f_cnt_q == F_LAST) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        conv_start      = 1'b1;
        s_ready_x       = adv & (x_cnt_q < X_FULL);
        xmem_wr_en      = s_valid_x & s_ready_x;
        en_pline_stages = adv;
        if (xmem_wr_en) begin
          x_cnt_d = x_cnt_q + XC_W'(1);
          if (x_cnt_q == X_LAST) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        conv_start      = 1'b1;
        en_pline_stages = adv;
        if (m_valid_y && m_ready_y && (out_cnt_q == N_LAST)) state_d = ST_DONE;
      end
      default: begin
        conv_done  = 1'b1;
        pline_clr  = 1'b1;
        f_cnt_d    = '0;
        x_cnt_d    = '0;
        out_cnt_d  = '0;
        win_pend_d = 1'b0;
        vbit_d     = '0;
        state_d    = ST_LOAD_F;
      end
    endcase

    if (state_q != ST_DONE) begin
      if (m_valid_y && m_ready_y) out_cnt_d = out_cnt_q + XC_W'(1);
      // A window exists once F_SIZE samples have been shifted in.
      if (adv) begin
        win_pend_d = xmem_wr_en & (x_cnt_q >= X_WIN_FIRST);
        vbit_d[0]  = win_pend_q;
        for (int k = 1; k < PLINE_STAGES; k++) vbit_d[k] = vbit_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_LOAD_F;
      f_cnt_q    <= '0;
      x_cnt_q    <= '0;
      out_cnt_q  <= '0;
      win_pend_q <= 1'b0;
      vbit_q     <= '0;
    end else begin
      state_q    <= state_d;
      f_cnt_q    <= f_cnt_d;
      x_cnt_q    <= x_cnt_d;
      out_cnt_q  <= out_cnt_d;
      win_pend_q <= win_pend_d;
      vbit_q     <= vbit_d;
    end
  end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb/tb_conv_seq_ctrl.sv - bench for conv_seq_ctrl with a behavioural datapath and golden convolution
module tb_conv_seq_ctrl;

  localparam int X_SIZE       = 128;
  localparam int F_SIZE       = 32;
  localparam int PLINE_STAGES = 3;
  localparam int N_OUT        = X_SIZE - F_SIZE + 1;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      s_valid_f;
  logic                      s_ready_f;
  logic                      fmem_wr_en;
  logic [$clog2(F_SIZE)-1:0] fmem_addr;
  logic                      s_valid_x;
  logic                      s_ready_x;
  logic                      xmem_wr_en;
  logic                      en_pline_stages;
  logic                      pline_clr;
  logic                      conv_start;
  logic                      m_valid_y;
  logic                      m_ready_y;
  logic                      conv_done;
  logic [7:0]                fdata;
  logic [7:0]                xdata;

  always #5 clk = ~clk;

  conv_seq_ctrl #(
    .X_SIZE(X_SIZE), .F_SIZE(F_SIZE), .PLINE_STAGES(PLINE_STAGES)
  ) dut (
    .clk(clk), .reset(reset),
    .s_valid_f(s_valid_f), .s_ready_f(s_ready_f),
    .fmem_wr_en(fmem_wr_en), .fmem_addr(fmem_addr),
    .s_valid_x(s_valid_x), .s_ready_x(s_ready_x),
    .xmem_wr_en(xmem_wr_en), .en_pline_stages(en_pline_stages),
    .pline_clr(pline_clr), .conv_start(conv_start),
    .m_valid_y(m_valid_y), .m_ready_y(m_ready_y),
    .conv_done(conv_done)
  );

  int fs[F_SIZE];
  int xs[X_SIZE];
  int gold[N_OUT];

  // Datapath stand-in driven only by the controller's strobes.
  int fmem[F_SIZE];
  int xwin[F_SIZE];
  int stg[PLINE_STAGES];

  function automatic int dot();
    int s = 0;
    for (int k = 0; k < F_SIZE; k++) s += fmem[k] * xwin[F_SIZE-1-k];
    return s;
  endfunction

  always @(posedge clk) begin
    if (fmem_wr_en) fmem[fmem_addr] <= int'(fdata);
    if (xmem_wr_en) begin
      xwin[0] <= int'(xdata);
      for (int k = 1; k < F_SIZE; k++) xwin[k] <= xwin[k-1];
    end
    if (pline_clr) begin
      for (int k = 0; k < PLINE_STAGES; k++) stg[k] <= 0;
    end else if (en_pline_stages) begin
      stg[0] <= dot();
      for (int k = 1; k < PLINE_STAGES; k++) stg[k] <= stg[k-1];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: golden result queued at X acceptance, popped at output handshake.
  int   q[$];
  int   mon_xi  = 0;
  int   n_y     = 0;
  int   n_done  = 0;
  logic done_prev = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        q.delete();
        mon_xi    = 0;
        done_prev = 1'b0;
      end else begin
        if (s_valid_x && s_ready_x) begin
          if (mon_xi >= F_SIZE - 1 && mon_xi < X_SIZE) q.push_back(gold[mon_xi-F_SIZE+1]);
          mon_xi++;
        end
        if (m_valid_y && m_ready_y) begin
          n_y++;
          check("y_expected_pending", int'(q.size() > 0), 1);
          if (q.size() > 0) check("y_data", stg[PLINE_STAGES-1], q.pop_front());
        end
        if (conv_done) begin
          n_done++;
          mon_xi = 0;
          check("q_empty_at_done", q.size(), 0);
          check("done_one_cycle", int'(done_prev), 0);
        end
        done_prev = conv_done;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic make_frame();
    for (int k = 0; k < F_SIZE; k++) fs[k] = int'($urandom_range(0, 15));
    for (int k = 0; k < X_SIZE; k++) xs[k] = int'($urandom_range(0, 15));
    for (int n = 0; n < N_OUT; n++) begin
      gold[n] = 0;
      for (int k = 0; k < F_SIZE; k++) gold[n] += fs[k] * xs[n+k];
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready_f"}, s_ready_f, 1);
    check({tag, "_s_ready_x"}, s_ready_x, 0);
    check({tag, "_m_valid_y"}, m_valid_y, 0);
    check({tag, "_conv_done"}, conv_done, 0);
    check({tag, "_conv_start"}, conv_start, 0);
    check({tag, "_pline_clr"}, pline_clr, 1);
    check({tag, "_fmem_addr"}, int'(fmem_addr), 0);
  endtask

  task automatic load_f_plain();
    int idx = 0;
    int budget = 0;
    s_valid_x = 1'b0;
    m_ready_y = 1'b1;
    while (idx < F_SIZE && budget < 200) begin
      s_valid_f = 1'b1;
      fdata     = 8'(fs[idx]);
      @(negedge clk);
      check("f_ready", s_ready_f, 1);
      check("f_addr", int'(fmem_addr), idx);
      if (s_valid_f && s_ready_f) idx++;
      cyc();
      budget++;
    end
    s_valid_f = 1'b0;
    check("f_load_complete", idx, F_SIZE);
  endtask

  task automatic run_x(input int x_duty, input int r_duty, input bit do_stall,
                       input int abort_at, input bit check_lat);
    int idx = 0;
    int cnum = 0;
    int acc_last_win0 = -1;
    int first_v = -1;
    int y0 = n_y;
    int d0 = n_done;
    bit stalled = 1'b0;
    bit done = 1'b0;
    while (!done && cnum < 6000) begin
      if (abort_at >= 0 && idx == abort_at) begin
        s_valid_x = 1'b0;
        m_ready_y = 1'b0;
        reset = 1'b0;
        #1;
        check_reset_outputs("abort");
        check("abort_no_done", n_done - d0, 0);
        cyc();
        reset = 1'b1;
        return;
      end
      if (do_stall && !stalled && m_valid_y && idx > 60) begin
        int yb = n_y;
        int sd = stg[PLINE_STAGES-1];
        stalled   = 1'b1;
        m_ready_y = 1'b0;
        s_valid_x = (idx < X_SIZE);
        xdata     = 8'(xs[(idx < X_SIZE) ? idx : 0]);
        repeat (10) begin
          @(negedge clk);
          check("stall_m_valid", m_valid_y, 1);
          check("stall_s_ready_x", s_ready_x, 0);
          check("stall_en", en_pline_stages, 0);
          check("stall_out_frozen", n_y, yb);
          check("stall_data_held", stg[PLINE_STAGES-1], sd);
          cyc();
        end
        continue;
      end
      s_valid_x = (idx < X_SIZE) && ($urandom_range(0, 99) < x_duty);
      xdata     = 8'(xs[(idx < X_SIZE) ? idx : 0]);
      m_ready_y = ($urandom_range(0, 99) < r_duty);
      @(negedge clk);
      check("xmem_wr_en", xmem_wr_en, int'(s_valid_x & s_ready_x));
      check("f_blocked_busy", s_ready_f, 0);
      check("en_rule", en_pline_stages, int'(!conv_done && (!m_valid_y || m_ready_y)));
      if (s_valid_x && s_ready_x) begin
        if (idx == F_SIZE - 1) acc_last_win0 = cnum;
        idx++;
      end
      if (m_valid_y && first_v < 0) first_v = cnum;
      if (conv_done) done = 1'b1;
      cyc();
      cnum++;
    end
    s_valid_x = 1'b0;
    check("frame_finished", int'(done), 1);
    check("frame_x_beats", idx, X_SIZE);
    check("frame_outputs", n_y - y0, N_OUT);
    check("frame_done_count", n_done - d0, 1);
    if (check_lat) check("first_y_latency", first_v - acc_last_win0, PLINE_STAGES + 1);
    @(negedge clk);
    check("rearm_s_ready_f", s_ready_f, 1);
    check("rearm_pline_clr", pline_clr, 1);
    check("rearm_conv_start", conv_start, 0);
    cyc();
  endtask

  typedef struct {
    logic sv_f;
    logic e_rdy_f;
    logic e_wr;
    int   e_addr;
    logic e_clr;
    logic e_start;
    logic e_rdy_x;
  } fvec_t;

  fvec_t tab[36];

  initial begin
    int idx;
    reset     = 1'b0;
    s_valid_f = 1'b0;
    s_valid_x = 1'b0;
    m_ready_y = 1'b0;
    fdata     = '0;
    xdata     = '0;
    make_frame();

    // F load with two bubbles, then two idle RUN cycles.
    idx = 0;
    for (int i = 0; i < 36; i++) begin
      tab[i].sv_f = !(i == 3 || i == 17);
      if (idx < F_SIZE) begin
        tab[i].e_rdy_f = 1'b1;
        tab[i].e_wr    = tab[i].sv_f;
        tab[i].e_addr  = idx;
        tab[i].e_clr   = 1'b1;
        tab[i].e_start = 1'b0;
        tab[i].e_rdy_x = 1'b0;
        if (tab[i].sv_f) idx++;
      end else begin
        tab[i].e_rdy_f = 1'b0;
        tab[i].e_wr    = 1'b0;
        tab[i].e_addr  = 0;
        tab[i].e_clr   = 1'b0;
        tab[i].e_start = 1'b1;
        tab[i].e_rdy_x = 1'b1;
      end
    end

    repeat (3) cyc();
    @(negedge clk);
    check_reset_outputs("reset");
    cyc();
    reset = 1'b1;
    m_ready_y = 1'b1;
    repeat (3) cyc();
    @(negedge clk);
    check_reset_outputs("idle");
    cyc();

    for (int i = 0; i < 36; i++) begin
      s_valid_f = tab[i].sv_f;
      fdata     = 8'(fs[tab[i].e_addr]);
      @(negedge clk);
      check("tab_s_ready_f", s_ready_f, tab[i].e_rdy_f);
      check("tab_fmem_wr_en", fmem_wr_en, tab[i].e_wr);
      if (tab[i].e_rdy_f) check("tab_fmem_addr", int'(fmem_addr), tab[i].e_addr);
      check("tab_pline_clr", pline_clr, tab[i].e_clr);
      check("tab_conv_start", conv_start, tab[i].e_start);
      check("tab_s_ready_x", s_ready_x, tab[i].e_rdy_x);
      cyc();
    end
    s_valid_f = 1'b0;
    run_x(100, 100, 1'b0, -1, 1'b1);

    make_frame();
    load_f_plain();
    run_x(100, 100, 1'b1, -1, 1'b0);

    make_frame();
    load_f_plain();
    run_x(50, 50, 1'b0, -1, 1'b0);

    make_frame();
    load_f_plain();
    run_x(100, 100, 1'b0, 50, 1'b0);
    @(negedge clk);
    check_reset_outputs("post_abort");
    cyc();

    make_frame();
    load_f_plain();
    run_x(100, 100, 1'b0, -1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
